// File: rtl/lane_controller.sv
// Lane-runner game controller: synchronised vsync frame tick, debounced buttons,
// intro sequence FSM (countdown/logo/drop/run) and rate-limited lane slide.

module lane_controller_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples;
  // a pulse is emitted only when the accepted level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          cnt   <= '0;
          press <= sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module lane_controller #(
  parameter int DEBOUNCE_CYCLES  = 1000000,
  parameter int COUNTDOWN_FRAMES = 5,
  parameter int LANE_STEP        = 100,
  parameter int SLIDE_RATE       = 20,
  parameter int COIN_MAX         = 80
) (
  input  logic               CLK100MHZ,
  input  logic               RESET,
  input  logic               vsync,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic signed [11:0] logo_voffset,
  output logic signed [11:0] head_hoffset,
  output logic signed [11:0] head_voffset,
  output logic signed [11:0] coin_loc,
  output logic [1:0]         lane,
  output logic [1:0]         phase
);
  typedef enum logic [1:0] {COUNTDOWN = 2'd0, LOGO = 2'd1, DROP = 2'd2, RUN = 2'd3} phase_t;

  localparam int FW = $clog2(COUNTDOWN_FRAMES + 1);
  localparam logic signed [11:0] STEP      = 12'(LANE_STEP);
  localparam logic signed [11:0] RATE      = 12'(SLIDE_RATE);
  localparam logic signed [11:0] COIN_LAST = 12'(COIN_MAX - 1);

  // vsync synchroniser plus edge detector
  logic [2:0] vs;
  logic       frame_tick;

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      vs         <= '0;
      frame_tick <= 1'b0;
    end else begin
      vs         <= {vs[1:0], vsync};
      frame_tick <= vs[1] & ~vs[2];
    end
  end

  // Buttons: index 0 = left, 1 = right
  logic [1:0] raw_btn, press;
  assign raw_btn = {btn_right, btn_left};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_btn
      lane_controller_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk(CLK100MHZ), .rst(RESET), .raw(raw_btn[g]), .press(press[g])
      );
    end
  endgenerate

  phase_t             state, state_d;
  logic [FW-1:0]      fcnt, fcnt_d;
  logic signed [11:0] logo_d, headv_d, headh_d, coin_d, target, diff;
  logic [1:0]         lane_d;

  always_comb begin
    state_d = state;
    fcnt_d  = fcnt;
    logo_d  = logo_voffset;
    headv_d = head_voffset;
    headh_d = head_hoffset;
    coin_d  = coin_loc;
    lane_d  = lane;
    target  = (lane == 2'd0) ? -STEP : (lane == 2'd2) ? STEP : 12'sd0;
    diff    = target - head_hoffset;

    if (frame_tick) begin
      unique case (state)
        COUNTDOWN: if (fcnt == '0) state_d = LOGO;
                   else            fcnt_d  = fcnt - 1'b1;
        LOGO:      if (logo_voffset < 12'sd640) logo_d  = logo_voffset + 12'sd30;
                   else                         state_d = DROP;
        DROP:      if (head_voffset > 12'sd50) headv_d = head_voffset - 12'sd17;
                   else begin
                     state_d = RUN;
                     coin_d  = 12'sd0;
                   end
        RUN:       coin_d = (coin_loc >= COIN_LAST) ? 12'sd0 : coin_loc + 12'sd1;
      endcase

      // Slide uses the target of the registered lane, so a same-cycle press
      // only takes effect on the following tick.
      if (diff > RATE)       headh_d = head_hoffset + RATE;
      else if (diff < -RATE) headh_d = head_hoffset - RATE;
      else                   headh_d = target;
    end

    if (state == RUN) begin
      unique case (press)
        2'b01:   if (lane != 2'd0) lane_d = lane - 2'd1;
        2'b10:   if (lane != 2'd2) lane_d = lane + 2'd1;
        default: lane_d = lane;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      state        <= COUNTDOWN;
      fcnt         <= FW'(COUNTDOWN_FRAMES);
      logo_voffset <= 12'sd0;
      head_voffset <= 12'sd180;
      head_hoffset <= 12'sd0;
      coin_loc     <= -12'sd50;
      lane         <= 2'd1;
    end else begin
      state        <= state_d;
      fcnt         <= fcnt_d;
      logo_voffset <= logo_d;
      head_voffset <= headv_d;
      head_hoffset <= headh_d;
      coin_loc     <= coin_d;
      lane         <= lane_d;
    end
  end

  assign phase = state;
endmodule

// File: doc/lane_controller.md
LANE_CONTROLLER -- requirements
Module: lane_controller

Interface
REQ-001 The block SHALL have one clock, CLK100MHZ; RESET is asynchronous and active-high.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, SHALL set the cycles a button must hold a new level before it is accepted.
REQ-003 Parameter COUNTDOWN_FRAMES, default 5, SHALL set the number of idle intro frames.
REQ-004 Parameter LANE_STEP, default 100, SHALL set the pixel distance between lane centres.
REQ-005 Parameter SLIDE_RATE, default 20, SHALL set the maximum head_hoffset change in pixels per frame.
REQ-006 Parameter COIN_MAX, default 80, SHALL set the coin_loc wrap point.
REQ-007 Ports SHALL be, in order:
- CLK100MHZ  in  1  system clock.
- RESET  in  1  asynchronous reset, active-high.
- vsync  in  1  VGA vertical sync, asynchronous to the logic.
- btn_left  in  1  raw left button, active-high.
- btn_right  in  1  raw right button, active-high.
- logo_voffset  out  12 signed  logo layer vertical offset.
- head_hoffset  out  12 signed  head layer horizontal offset.
- head_voffset  out  12 signed  head layer vertical offset.
- coin_loc  out  12 signed  coin scroll position.
- lane  out  2  current lane: 0 = left, 1 = centre, 2 = right.
- phase  out  2  FSM state: 0 = COUNTDOWN, 1 = LOGO, 2 = DROP, 3 = RUN.

Function
REQ-008 vsync SHALL pass through a 2-flop synchroniser; frame_tick SHALL be a one-cycle pulse on the synchronised 0->1 edge, 3 cycles after vsync rises.
REQ-009 Each button SHALL have a 2-flop synchroniser and a debouncer; the debounced level SHALL change only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-010 A press SHALL be a one-cycle pulse on a debounced 0->1 edge; releases SHALL produce no pulse.
REQ-011 The frame counter SHALL load COUNTDOWN_FRAMES in COUNTDOWN and decrement on each frame_tick; the tick that finds it at 0 SHALL move the FSM to LOGO.
REQ-012 LOGO: each frame_tick SHALL add 30 to logo_voffset while it is below 640; the tick that finds it at or above 640 SHALL move the FSM to DROP.
REQ-013 DROP: each frame_tick SHALL subtract 17 from head_voffset while it is above 50; the tick that finds it at or below 50 SHALL move the FSM to RUN and set coin_loc to 0.
REQ-014 RUN: each frame_tick SHALL increment coin_loc, and SHALL wrap coin_loc to 0 when it reaches COIN_MAX.
REQ-015 RUN is terminal; only RESET SHALL leave it.
REQ-016 Lane presses SHALL be accepted only in RUN; presses in other states SHALL be discarded, not queued.
REQ-017 A left press SHALL decrement lane, saturating at 0.
REQ-018 A right press SHALL increment lane, saturating at 2.
REQ-019 Left and right presses in the same cycle SHALL leave lane unchanged.
REQ-020 The lane target SHALL be (lane - 1) * LANE_STEP, signed 12-bit.
REQ-021 On each frame_tick, head_hoffset SHALL move toward the target by min(SLIDE_RATE, |target - head_hoffset|), never overshooting.
REQ-022 A lane change mid-slide SHALL retarget from the current head_hoffset.
REQ-023 A press and a frame_tick in the same cycle SHALL update lane first; the slide SHALL use the new target on the next frame_tick.
REQ-024 All arithmetic SHALL be 12-bit two's-complement.
REQ-025 All outputs SHALL be registered and change only on CLK100MHZ rising edges.

Reset
REQ-026 Asserting RESET at any time, including mid-slide or mid-intro, SHALL set the following immediately:
- phase = 0, frame counter = COUNTDOWN_FRAMES
- logo_voffset = 0, head_voffset = 180, head_hoffset = 0, coin_loc = -50, lane = 1
- debounced levels = 0, synchronisers = 0
REQ-027 After RESET deasserts, the first frame_tick SHALL be counted normally and no spurious press SHALL be generated.

Verification
REQ-028 Parameters SHALL be DEBOUNCE_CYCLES=4 and COUNTDOWN_FRAMES=2, and SHALL be stated per scenario where they differ.
REQ-029 Intro: reset, then 6 vsync pulses -> phase 1, logo_voffset 0, 30, ... to 660 after 22 LOGO ticks, then phase 2; head_voffset 180 -> 44 after 8 DROP ticks, then phase 3 with coin_loc 0.
REQ-030 Lane saturation: in RUN, 3 right presses -> lane 2; over 5 frames head_hoffset 20, 40, 60, 80, 100, then holds at 100.
REQ-031 Retarget and simultaneity: with head_hoffset at 60 sliding right, a left press -> target 0, next ticks 40, 20, 0; left+right in the same cycle -> lane unchanged.
REQ-032 Debounce: a 3-cycle btn_right glitch -> no press; a 4-cycle stable high -> exactly one press; a press during LOGO -> lane stays 1.
REQ-033 Wrap and reset: coin_loc 79 plus one tick -> 0; RESET mid-slide -> all outputs equal REQ-026 values in the same cycle.
